// File: rtl/alu_exec_pkg.sv
// Shared ALUCtrl code constants and execute-unit FSM state type.
// The ALU controller uses the same code constants.
package alu_exec_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_LUI  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SRAV = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

  function automatic logic is_shift_op(input logic [3:0] ctrl);
    return (ctrl == ALU_SRA) || (ctrl == ALU_SRAV);
  endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Combinational single-cycle ALU operations plus the illegal-code flag.
// Shift codes pass src2 through, which is the zero-amount shift result.
module alu_comb_core
  import alu_exec_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        ctrl,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  output logic [DATA_W-1:0] result,
  output logic              illegal
);

  logic slt_bit;

  assign slt_bit = ($signed(src1) < $signed(src2));

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    unique case (ctrl)
      ALU_AND:  result = src1 & src2;
      ALU_OR:   result = src1 | src2;
      ALU_ADD:  result = src1 + src2;
      ALU_SUB:  result = src1 - src2;
      ALU_SLT:  result = {{(DATA_W-1){1'b0}}, slt_bit};
      ALU_LUI:  result = src2 << 16;
      ALU_SRA,
      ALU_SRAV: result = src2;
      default: begin
        result  = '0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage unit: registered single-cycle ALU ops and iterative
// one-bit-per-cycle arithmetic right shifts behind valid/ready handshakes.
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SH_W   = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [3:0]        ALUCtrl_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  input  logic [SH_W-1:0]   shamt_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              illegal_o,
  output alu_state_e        state_o
);

  // Handshake: an op transfers on a rising edge where valid_i && ready_o;
  // a result transfers on a rising edge where valid_o && ready_i. ready_o is
  // only high in IDLE, so a consume and a new accept never share a cycle.

  alu_state_e        state_q, state_d;
  logic [DATA_W-1:0] shreg_q;
  logic [SH_W-1:0]   cnt_q;
  logic [DATA_W-1:0] result_q;
  logic              zero_q;
  logic              illegal_q;

  logic [DATA_W-1:0] core_result;
  logic              core_illegal;
  logic [SH_W-1:0]   accept_amt;
  logic [DATA_W-1:0] shreg_next;
  logic              load_core;
  logic              load_shift;
  logic              shift_step;
  logic              shift_last;

  alu_comb_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .ctrl    (ALUCtrl_i),
    .src1    (src1_i),
    .src2    (src2_i),
    .result  (core_result),
    .illegal (core_illegal)
  );

  assign accept_amt = (ALUCtrl_i == ALU_SRA) ? shamt_i : src1_i[SH_W-1:0];
  assign shreg_next = {shreg_q[DATA_W-1], shreg_q[DATA_W-1:1]};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ready_o    = 1'b0;
    valid_o    = 1'b0;
    load_core  = 1'b0;
    load_shift = 1'b0;
    shift_step = 1'b0;
    shift_last = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          if (is_shift_op(ALUCtrl_i) && (accept_amt != '0)) begin
            load_shift = 1'b1;
            state_d    = ST_SHIFT;
          end else begin
            load_core = 1'b1;
            state_d   = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        shift_step = 1'b1;
        if (cnt_q == SH_W'(1)) begin
          shift_last = 1'b1;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        valid_o = 1'b1;
        if (ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      shreg_q   <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      if (load_shift) begin
        shreg_q <= src2_i;
        cnt_q   <= accept_amt;
      end else if (shift_step) begin
        shreg_q <= shreg_next;
        cnt_q   <= cnt_q - SH_W'(1);
      end
      if (load_core) begin
        result_q  <= core_result;
        zero_q    <= (core_result == '0);
        illegal_q <= core_illegal;
      end else if (shift_last) begin
        result_q  <= shreg_next;
        zero_q    <= (shreg_next == '0);
        illegal_q <= 1'b0;
      end
    end
  end

  assign result_o  = result_q;
  assign zero_o    = zero_q;
  assign illegal_o = illegal_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit with hand-computed expected values.
module tb_alu_exec_unit;
  import alu_exec_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic        ready_out;
  logic [3:0]  ctrl;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [4:0]  shamt;
  logic        valid_out;
  logic        ready_in;
  logic [31:0] result;
  logic        zero;
  logic        illegal;
  alu_state_e  state;

  int total = 0;
  int bad   = 0;

  alu_exec_unit #(.DATA_W(32), .SH_W(5)) dut (
    .clk_i     (clk),
    .rst_i     (rst_n),
    .valid_i   (valid_in),
    .ready_o   (ready_out),
    .ALUCtrl_i (ctrl),
    .src1_i    (src1),
    .src2_i    (src2),
    .shamt_i   (shamt),
    .valid_o   (valid_out),
    .ready_i   (ready_in),
    .result_o  (result),
    .zero_o    (zero),
    .illegal_o (illegal),
    .state_o   (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op, wait for the result, check it, then consume it.
  task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh, input int exp_lat,
                        input logic [31:0] exp_res, input logic exp_zero, input logic exp_ill);
    int lat;
    ctrl = c; src1 = a; src2 = b; shamt = sh;
    valid_in = 1'b1;
    ready_in = 1'b0;
    check({tag, "_ready"}, 32'(ready_out), 32'd1);
    step();
    valid_in = 1'b0;
    ctrl = 4'b1111; src1 = $urandom; src2 = $urandom; shamt = 5'($urandom_range(0, 31));
    lat = 0;
    while (!valid_out && lat < 64) begin
      step();
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_res"}, result, exp_res);
    check({tag, "_zero"}, 32'(zero), 32'(exp_zero));
    check({tag, "_ill"}, 32'(illegal), 32'(exp_ill));
    ready_in = 1'b1;
    step();
    ready_in = 1'b0;
    check({tag, "_consumed"}, 32'(valid_out), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; ready_in = 1'b0;
    ctrl = 4'b0; src1 = '0; src2 = '0; shamt = '0;
    // reset held: inputs active must not matter
    valid_in = 1'b1; ctrl = ALU_ADD; src1 = 32'd7; src2 = 32'd9;
    repeat (3) step();
    check("rst_ready", 32'(ready_out), 32'd1);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_ill", 32'(illegal), 32'd0);
    check("rst_state", 32'(state), 32'(ST_IDLE));
    valid_in = 1'b0;
    rst_n = 1'b1;
    step();

    run_op("add_ovf", ALU_ADD, 32'h7FFF_FFFF, 32'h1, 5'd0, 0, 32'h8000_0000, 1'b0, 1'b0);
    run_op("sub_zero", ALU_SUB, 32'd5, 32'd5, 5'd0, 0, 32'h0, 1'b1, 1'b0);
    run_op("slt_neg", ALU_SLT, 32'hFFFF_FFFF, 32'h1, 5'd0, 0, 32'h1, 1'b0, 1'b0);
    run_op("slt_false", ALU_SLT, 32'h1, 32'hFFFF_FFFF, 5'd0, 0, 32'h0, 1'b1, 1'b0);
    run_op("lui", ALU_LUI, 32'hDEAD_BEEF, 32'h0000_1234, 5'd0, 0, 32'h1234_0000, 1'b0, 1'b0);
    run_op("and", ALU_AND, 32'h0000_F0F0, 32'h0000_FF00, 5'd0, 0, 32'h0000_F000, 1'b0, 1'b0);
    run_op("or", ALU_OR, 32'h0000_F0F0, 32'h0F00_FF00, 5'd0, 0, 32'h0F00_FFF0, 1'b0, 1'b0);
    run_op("sra4", ALU_SRA, 32'h0, 32'h8000_0000, 5'd4, 4, 32'hF800_0000, 1'b0, 1'b0);
    run_op("srav_amt0", ALU_SRAV, 32'd32, 32'h8000_00F0, 5'd7, 0, 32'h8000_00F0, 1'b0, 1'b0);
    run_op("srav3", ALU_SRAV, 32'd3, 32'h0000_0F00, 5'd9, 3, 32'h0000_01E0, 1'b0, 1'b0);
    run_op("sra31", ALU_SRA, 32'h0, 32'h8000_0000, 5'd31, 31, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("sra_pos_zero", ALU_SRA, 32'h0, 32'h0000_0001, 5'd1, 1, 32'h0, 1'b1, 1'b0);
    run_op("illegal", 4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3, 0, 32'h0, 1'b1, 1'b1);

    // backpressure: result held, new requests ignored while in DONE
    ctrl = ALU_ADD; src1 = 32'd10; src2 = 32'd20; valid_in = 1'b1; ready_in = 1'b0;
    step();
    valid_in = 1'b1; ctrl = ALU_OR; src1 = 32'hFFFF_0000; src2 = 32'h0000_FFFF;
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", 32'(valid_out), 32'd1);
      check("bp_ready", 32'(ready_out), 32'd0);
      check("bp_result", result, 32'd30);
      step();
    end
    check("bp_result_end", result, 32'd30);
    valid_in = 1'b0;
    ready_in = 1'b1;
    step();
    ready_in = 1'b0;
    check("bp_release_valid", 32'(valid_out), 32'd0);
    check("bp_release_ready", 32'(ready_out), 32'd1);
    step();
    check("bp_no_accept", 32'(valid_out), 32'd0);

    // reset mid-shift aborts the op without a result
    ctrl = ALU_SRA; src2 = 32'h8000_0000; shamt = 5'd20; valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    repeat (5) step();
    check("mid_state", 32'(state), 32'(ST_SHIFT));
    rst_n = 1'b0;
    #1;
    check("abort_state", 32'(state), 32'(ST_IDLE));
    check("abort_ready", 32'(ready_out), 32'd1);
    check("abort_valid", 32'(valid_out), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    begin
      int seen = 0;
      for (int i = 0; i < 25; i++) begin
        if (valid_out) seen++;
        step();
      end
      check("abort_no_pulse", 32'(seen), 32'd0);
    end
    run_op("post_rst_sra", ALU_SRA, 32'h0, 32'h4000_0000, 5'd2, 2, 32'h1000_0000, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

- Execute-stage unit directly downstream of the ALU controller.
- Consumes its 4-bit `ALUCtrl` code plus register/immediate operands and produces a registered result and zero flag for branch resolution and writeback.
- Single-cycle ops (add, sub, and, or, slt, lui) complete in one cycle; arithmetic shifts (SRA, SRAV) run iteratively, one bit per cycle.
- Valid/ready handshake on both sides lets the pipeline stall.

## Interface

Parameters:
- `DATA_W`, default 32, datapath width.
- `SH_W`, default 5, shift-amount width, equal to log2(`DATA_W`).

Ports:
- `clk_i` input 1: single clock, rising edge.
- `rst_i` input 1: reset, asynchronous, active-low.
- `valid_i` input 1: upstream operands and control valid.
- `ready_o` output 1: unit can accept a new operation.
- `ALUCtrl_i` input 4: operation code from the ALU controller.
- `src1_i` input `DATA_W`: rs operand.
- `src2_i` input `DATA_W`: rt or immediate operand.
- `shamt_i` input `SH_W`: instruction shamt field.
- `valid_o` output 1: result valid.
- `ready_i` input 1: downstream accepts the result.
- `result_o` output `DATA_W`: registered result.
- `zero_o` output 1: `result_o` == 0.
- `illegal_o` output 1: accepted code was not in the supported set.

## Operation

Control codes:
- `0000` AND: `src1 & src2`.
- `0001` OR: `src1 | src2`.
- `0010` ADD: `src1 + src2`, modulo 2^`DATA_W`, no overflow trap.
- `0110` SUB: `src1 - src2`, modulo 2^`DATA_W`.
- `0111` SLT: signed `src1 < src2` gives 1, else 0, zero-extended.
- `0011` LUI: `{src2[15:0], 16'b0}`.
- `1000` SRA: `src2` arithmetic-shifted right by `shamt_i`.
- `1001` SRAV: `src2` arithmetic-shifted right by `src1[SH_W-1:0]`.
- Any other code: `result` = 0, `illegal_o` = 1.

FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - `ready_o` = 1.
  - On `valid_i`, the op is accepted.
  - Non-shift op, or shift with amount 0: register the result (amount 0 gives `src2`), go to DONE.
  - Shift with amount n > 0: load `shreg` = `src2` and `cnt` = n, go to SHIFT.
- SHIFT:
  - `ready_o` = 0.
  - Each cycle: `shreg` = {`shreg`[MSB], `shreg`[MSB:1]}, `cnt` decrements.
  - When `cnt` == 1, the final shift is written to `result_o` and the FSM goes to DONE.
- DONE:
  - `valid_o` = 1, `ready_o` = 0.
  - `result_o`, `zero_o` and `illegal_o` are held stable while `ready_i` = 0.
  - On `ready_i`, go to IDLE.
- Operands are captured at accept; later changes on `src*_i`, `shamt_i` or `ALUCtrl_i` have no effect.
- `zero_o` and `illegal_o` are registered together with `result_o`.

## Timing

- Reset values: state IDLE, `ready_o` = 1, `valid_o` = 0, `result_o` = 0, `zero_o` = 0, `illegal_o` = 0, `cnt` = 0.
- Single-cycle ops and zero-amount shifts: accept at edge k, `valid_o` high after edge k.
- Shift by n > 0: `valid_o` high after edge k+n.
- Reset asserted mid-SHIFT or mid-DONE: the op is aborted immediately, no `valid_o` is produced, and the FSM returns to IDLE.
- No new accept occurs in the same cycle the result is consumed. The earliest next accept is the cycle after DONE→IDLE, so throughput is at most one op per 2 cycles.
- Shift by `DATA_W`-1 of a negative value yields all ones. Sign replication is exact on every step.
- `valid_i` while `ready_o` = 0 is ignored. Upstream holds its request.

## Structure

- Shared package `alu_exec_pkg`:
  - `ALUCtrl` code constants: `ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_SUB`, `ALU_SLT`, `ALU_LUI`, `ALU_SRA`, `ALU_SRAV`.
  - FSM state enum.
- The same code constants are to be used by the ALU controller.
- One sub-module, `alu_comb_core`: purely combinational single-cycle ops plus the illegal-code flag.
- The FSM, shift register and counter live in `alu_exec_unit`.

## Test plan

- Reset: hold `rst_i` = 0 → `ready_o` = 1, `valid_o` = 0, `result_o` = 0 while reset is held.
- ADD 0x7FFFFFFF+1 → `result_o` 0x80000000 one cycle after accept. SUB 5-5 → 0 with `zero_o` = 1.
- SLT -1 vs 1 → `result_o` 1. LUI `src2` = 0x1234 → `result_o` 0x12340000.
- SRA `src2` = 0x80000000, `shamt_i` = 4 → `valid_o` 4 cycles after accept, `result_o` 0xF8000000. SRAV with `src1` = 32 (amount 0) → `src2` unchanged, latency 1.
- Backpressure: `ready_i` = 0 for 3 cycles in DONE → `result_o` stable, `ready_o` = 0, new `valid_i` ignored. Code `1111` → `illegal_o` = 1, `result_o` = 0.
- Reset asserted mid-SHIFT (amount 20) → immediate IDLE, no `valid_o` pulse. Next op completes normally.
